// File: rtl/ita_div_bank.sv
// Bank of NumDiv independent restoring dividers computing saturated Numerator / divisor.
// Define ITA_DIV_BANK_RADIX4_EN to retire two quotient bits per BUSY cycle.
module ita_div_bank #(
    parameter int unsigned          NumDiv       = 4,
    parameter int unsigned          InWidth      = 16,
    parameter int unsigned          DividerWidth = 16,
    parameter int unsigned          NumWidth     = 24,
    parameter logic [NumWidth-1:0]  Numerator    = 24'h800000
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [InWidth-1:0]               div_inp_i,
    input  logic [NumDiv-1:0]                div_valid_i,
    output logic [NumDiv-1:0]                div_ready_o,
    output logic [NumDiv-1:0]                div_valid_o,
    input  logic [NumDiv-1:0]                div_ready_i,
    output logic [NumDiv*DividerWidth-1:0]   div_oup_o
);

`ifdef ITA_DIV_BANK_RADIX4_EN
    localparam int unsigned Steps = NumWidth / 2;
`else
    localparam int unsigned Steps = NumWidth;
`endif
    localparam int unsigned CntWidth = $clog2(Steps + 1);
    localparam logic [NumWidth-1:0] MaxQuo = NumWidth'({DividerWidth{1'b1}});

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    for (genvar g = 0; g < NumDiv; g++) begin : g_lane
        state_e                   state_q;
        logic [InWidth-1:0]       div_q;
        logic [InWidth:0]         rem_q;
        // Dividend bits shift out at the top while quotient bits shift in at the bottom.
        logic [NumWidth-1:0]      dq_q;
        logic [CntWidth-1:0]      cnt_q;
        logic [DividerWidth-1:0]  oup_q;

        logic [InWidth:0]         trial_a, rem_a, rem_n;
        logic                     bit_a;
        logic [NumWidth-1:0]      dq_n;
        logic                     sat;
`ifdef ITA_DIV_BANK_RADIX4_EN
        logic [InWidth:0]         trial_b, rem_b;
        logic                     bit_b;
`endif

        always_comb begin
            trial_a = {rem_q[InWidth-1:0], dq_q[NumWidth-1]};
            bit_a   = rem_q[InWidth] | (trial_a >= {1'b0, div_q});
            rem_a   = bit_a ? (trial_a - {1'b0, div_q}) : trial_a;
`ifdef ITA_DIV_BANK_RADIX4_EN
            trial_b = {rem_a[InWidth-1:0], dq_q[NumWidth-2]};
            bit_b   = rem_a[InWidth] | (trial_b >= {1'b0, div_q});
            rem_b   = bit_b ? (trial_b - {1'b0, div_q}) : trial_b;
            rem_n   = rem_b;
            dq_n    = {dq_q[NumWidth-3:0], bit_a, bit_b};
`else
            rem_n   = rem_a;
            dq_n    = {dq_q[NumWidth-2:0], bit_a};
`endif
            sat     = dq_n > MaxQuo;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= StIdle;
                div_q   <= '0;
                rem_q   <= '0;
                dq_q    <= '0;
                cnt_q   <= '0;
                oup_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (div_valid_i[g]) begin
                            div_q <= div_inp_i;
                            rem_q <= '0;
                            dq_q  <= Numerator;
                            cnt_q <= CntWidth'(Steps - 1);
                            if (div_inp_i == '0) begin
                                oup_q   <= '1;
                                state_q <= StDone;
                            end else begin
                                state_q <= StBusy;
                            end
                        end
                    end
                    StBusy: begin
                        rem_q <= rem_n;
                        dq_q  <= dq_n;
                        cnt_q <= cnt_q - CntWidth'(1);
                        if (cnt_q == '0) begin
                            oup_q   <= sat ? '1 : dq_n[DividerWidth-1:0];
                            state_q <= StDone;
                        end
                    end
                    StDone: begin
                        if (div_ready_i[g]) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end

        assign div_ready_o[g] = (state_q == StIdle);
        assign div_valid_o[g] = (state_q == StDone);
        assign div_oup_o[g*DividerWidth +: DividerWidth] = oup_q;
    end

endmodule

// File: tb/tb_ita_div_bank.sv
// Self-checking bench for ita_div_bank: vector table plus scoreboarded corner-case sequences.
module tb_ita_div_bank;

    localparam int NumDiv = 4;
`ifdef ITA_DIV_BANK_RADIX4_EN
    localparam int LatNz = 13;
`else
    localparam int LatNz = 25;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] div_inp_i;
    logic [3:0]  div_valid_i;
    logic [3:0]  div_ready_o;
    logic [3:0]  div_valid_o;
    logic [3:0]  div_ready_i;
    logic [63:0] div_oup_o;

    ita_div_bank dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .div_inp_i   (div_inp_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .div_valid_o (div_valid_o),
        .div_ready_i (div_ready_i),
        .div_oup_o   (div_oup_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb [NumDiv][$];

    typedef struct {
        logic [15:0] d;
        logic [15:0] q;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d);
        longint q;
        if (d == 16'd0) return 16'hFFFF;
        q = 64'd8388608 / d;
        if (q > 65535) return 16'hFFFF;
        return q[15:0];
    endfunction

    function automatic logic [15:0] lane_oup(input int lane);
        return div_oup_o[lane*16 +: 16];
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic issue(input int lane, input logic [15:0] d, input logic [15:0] exp);
        check("ready_before_issue", div_ready_o[lane], 1'b1);
        div_inp_i         = d;
        div_valid_i[lane] = 1'b1;
        sb[lane].push_back(exp);
        @(negedge clk);
        div_valid_i[lane] = 1'b0;
    endtask

    task automatic wait_valid(input int lane, output int n);
        n = 0;
        while (!div_valid_o[lane] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", div_valid_o[lane], 1'b1);
    endtask

    task automatic collect(input int lane, input string name);
        logic [15:0] exp;
        if (sb[lane].size() == 0) begin
            check("scoreboard_empty", 64'(sb[lane].size()), 64'd1);
        end else begin
            exp = sb[lane].pop_front();
            check(name, lane_oup(lane), exp);
        end
        div_ready_i[lane] = 1'b1;
        @(negedge clk);
        div_ready_i[lane] = 1'b0;
        check("valid_after_release", div_valid_o[lane], 1'b0);
        check("ready_after_release", div_ready_o[lane], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int lane;
        logic [15:0] held;

        vecs[0]  = '{16'd256,   16'h8000};
        vecs[1]  = '{16'd1,     16'hFFFF};
        vecs[2]  = '{16'd0,     16'hFFFF};
        vecs[3]  = '{16'd300,   16'd27962};
        vecs[4]  = '{16'd301,   16'd27869};
        vecs[5]  = '{16'd302,   16'd27776};
        vecs[6]  = '{16'd303,   16'd27685};
        vecs[7]  = '{16'd65535, 16'd128};
        vecs[8]  = '{16'd128,   16'hFFFF};
        vecs[9]  = '{16'd129,   16'd65027};
        vecs[10] = '{16'd1000,  16'd8388};
        vecs[11] = '{16'd40000, 16'd209};

        rst_i       = 1'b1;
        div_inp_i   = '0;
        div_valid_i = '0;
        div_ready_i = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", div_ready_o, 4'hF);
        check("reset_valid", div_valid_o, 4'h0);
        check("reset_oup", div_oup_o, 64'h0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_ready", div_ready_o, 4'hF);
        check("idle_valid", div_valid_o, 4'h0);

        // Table-driven single requests, rotating over lanes.
        for (int i = 0; i < 12; i++) begin
            lane = i % NumDiv;
            issue(lane, vecs[i].d, vecs[i].q);
            wait_valid(lane, n);
            check("latency", 64'(n + 1), (vecs[i].d == 16'd0) ? 64'd1 : 64'(LatNz));
            collect(lane, "table_quotient");
        end

        // Round-robin stream with a fifth request held on lane 0.
        for (int i = 0; i < NumDiv; i++) begin
            issue(i, 16'(300 + i), model(16'(300 + i)));
        end
        div_inp_i      = 16'd999;
        div_valid_i[0] = 1'b1;
        n = 0;
        while (!div_valid_o[0] && n < 200) begin
            check("stream_lane0_not_ready", div_ready_o[0], 1'b0);
            @(negedge clk);
            n++;
        end
        check("stream_order0", div_valid_o, 4'b0001);
        @(negedge clk);
        check("stream_order1", div_valid_o, 4'b0011);
        @(negedge clk);
        check("stream_order2", div_valid_o, 4'b0111);
        @(negedge clk);
        check("stream_order3", div_valid_o, 4'b1111);
        check("stream_lane0_done_not_ready", div_ready_o[0], 1'b0);
        collect(0, "stream_q0");
        sb[0].push_back(model(16'd999));
        @(negedge clk);
        div_valid_i[0] = 1'b0;
        check("stream_fifth_accepted", div_ready_o[0], 1'b0);
        collect(1, "stream_q1");
        collect(2, "stream_q2");
        collect(3, "stream_q3");
        wait_valid(0, n);
        collect(0, "stream_fifth_q");

        // Backpressure on lane 2.
        issue(2, 16'd500, model(16'd500));
        wait_valid(2, n);
        held = lane_oup(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_held", div_valid_o[2], 1'b1);
            check("bp_data_held", lane_oup(2), held);
        end
        collect(2, "bp_quotient");

        // Protocol abuse: valid and result-ready while busy.
        issue(1, 16'd1000, model(16'd1000));
        div_inp_i      = 16'd7;
        div_valid_i[1] = 1'b1;
        div_ready_i[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abuse_ready", div_ready_o[1], 1'b0);
            check("abuse_valid", div_valid_o[1], 1'b0);
        end
        div_valid_i[1] = 1'b0;
        div_ready_i[1] = 1'b0;
        wait_valid(1, n);
        check("abuse_latency", 64'(n + 4), 64'(LatNz));
        collect(1, "abuse_quotient");

        // All four lanes share one divisor.
        div_inp_i   = 16'd777;
        div_valid_i = 4'hF;
        for (int i = 0; i < NumDiv; i++) sb[i].push_back(model(16'd777));
        @(negedge clk);
        div_valid_i = 4'h0;
        check("all4_busy", div_ready_o, 4'h0);
        wait_valid(0, n);
        check("all4_valid", div_valid_o, 4'hF);
        for (int i = 0; i < NumDiv; i++) collect(i, "all4_quotient");

        // Fill lanes 1..3 with results so the asynchronous reset has data to clear.
        div_inp_i   = 16'd3000;
        div_valid_i = 4'hE;
        @(negedge clk);
        div_valid_i = 4'h0;
        wait_valid(1, n);

        // Asynchronous reset while lanes 0 and 1 are busy.
        div_ready_i = 4'hE;
        @(negedge clk);
        div_ready_i = 4'h0;
        issue(0, 16'd300, model(16'd300));
        issue(1, 16'd301, model(16'd301));
        repeat (5) @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        check("midreset_ready", div_ready_o, 4'hF);
        check("midreset_valid", div_valid_o, 4'h0);
        check("midreset_oup", div_oup_o, 64'h0);
        sb[0].delete();
        sb[1].delete();
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        issue(0, 16'd1000, model(16'd1000));
        wait_valid(0, n);
        check("post_reset_latency", 64'(n + 1), 64'(LatNz));
        collect(0, "post_reset_quotient");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
